// File: rtl/crc_frame_check.sv
// rtl/crc_frame_check.sv - CRC-8 frame checker: buffers payload, checks trailing CRC, drains tagged bytes
// Optional: define CRC_DROP_BAD_EN to discard failed frames instead of draining them with out_err=1.
module crc_frame_check #(
  parameter int          FRAME_BYTES = 8,
  parameter logic [7:0]  POLY        = 8'h07,
  parameter logic [7:0]  INIT        = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_err,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] err_count
);

  localparam int             IW       = $clog2(FRAME_BYTES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(FRAME_BYTES - 1);
  localparam logic [IW-1:0]  LAST_PAY = IW'(FRAME_BYTES - 2);

  typedef enum logic [1:0] {RECV, CHECK, DRAIN} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] rptr_q;
  logic [7:0]    crc_q;
  logic [7:0]    crc_d;
  logic [7:0]    buf_q [FRAME_BYTES-1];
  logic          crc_ok_q;
  logic          crc_err_q;
  logic          out_err_q;
  logic [15:0]   err_cnt_q;
  logic          in_fire;
  logic          out_fire;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  assign crc_d     = crc8_byte(crc_q, in_data);
  assign in_ready  = (state_q == RECV);
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? buf_q[rptr_q] : 8'h00;
  assign out_last  = out_valid && (rptr_q == LAST_PAY);
  assign out_err   = out_err_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign err_count = err_cnt_q;

  always_ff @(posedge clk) begin
    if (in_fire && (idx_q != LAST_IDX)) begin
      buf_q[idx_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RECV;
      idx_q     <= '0;
      rptr_q    <= '0;
      crc_q     <= INIT;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      out_err_q <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else begin
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      case (state_q)
        RECV: begin
          if (in_fire) begin
            // The final byte of the frame is the received CRC, not payload.
            if (idx_q == LAST_IDX) begin
              crc_ok_q  <= (in_data == crc_q);
              crc_err_q <= (in_data != crc_q);
              state_q   <= CHECK;
            end else begin
              crc_q <= crc_d;
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        CHECK: begin
          rptr_q <= '0;
          if (crc_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
`ifdef CRC_DROP_BAD_EN
          out_err_q <= 1'b0;
          if (crc_err_q) begin
            state_q <= RECV;
            crc_q   <= INIT;
            idx_q   <= '0;
          end else begin
            state_q <= DRAIN;
          end
`else
          out_err_q <= crc_err_q;
          state_q   <= DRAIN;
`endif
        end
        DRAIN: begin
          if (out_fire) begin
            if (rptr_q == LAST_PAY) begin
              state_q   <= RECV;
              crc_q     <= INIT;
              idx_q     <= '0;
              rptr_q    <= '0;
              out_err_q <= 1'b0;
            end else begin
              rptr_q <= rptr_q + IW'(1);
            end
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_check.sv
// tb/tb_crc_frame_check.sv - scoreboard bench for crc_frame_check
module tb_crc_frame_check;

  localparam int FB = 8;
`ifdef CRC_DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        out_err;
  logic        crc_ok;
  logic        crc_err;
  logic [15:0] err_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [9:0]  exp_q [$];
  logic [15:0] exp_errs = 16'h0000;
  logic [7:0]  pay [FB-1];
  bit          tog_en = 1'b0;
  int          tog_k = 0;
  logic [3:0]  tog_pat = 4'b1001;
  logic        hold_pending = 1'b0;
  logic [9:0]  held = 10'h000;

  crc_frame_check #(.FRAME_BYTES(FB), .POLY(8'h07), .INIT(8'h00)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_err(out_err),
    .crc_ok(crc_ok), .crc_err(crc_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // bit-serial reference CRC, MSB first
  function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_crc();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < FB-1; i++) c = ref_crc(c, pay[i]);
    return c;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (tog_en) begin
      out_ready = tog_pat[tog_k];
      tog_k = (tog_k + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_stable", {out_data, out_last, out_err}, held);
      end
      if (out_valid) begin
        check("in_ready_drain", in_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
          else check("out_byte", {out_data, out_last, out_err}, exp_q.pop_front());
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {out_data, out_last, out_err};
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", in_ready, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] crc_byte);
    logic good;
    good = (frame_crc() == crc_byte);
    if (good || !DROP) begin
      for (int i = 0; i < FB-1; i++) exp_q.push_back({pay[i], (i == FB-2), !good});
    end
    for (int i = 0; i < FB-1; i++) send_byte(pay[i]);
    send_byte(crc_byte);
    check("crc_ok", crc_ok, good);
    check("crc_err", crc_err, !good);
    check("in_ready_check", in_ready, 0);
    check("no_valid_check", out_valid, 0);
    if (!good && exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;
    @(negedge clk);
    check("pulse_one_cycle", {crc_ok, crc_err}, 0);
    check("err_count", err_count, exp_errs);
    if (DROP && !good) begin
      check("dropped_no_valid", out_valid, 0);
      check("dropped_in_ready", in_ready, 1);
      check("dropped_out_err", out_err, 0);
    end else begin
      check("first_valid", out_valid, 1);
    end
    wait_drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_err", out_err, 0);
    check("rst_pulses", {crc_ok, crc_err}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < FB-1; i++) pay[i] = 8'h00;
    send_frame(8'h00);

    pay[FB-2] = 8'h01;
    send_frame(8'h07);

    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_pulses", {crc_ok, crc_err}, 0);
    check("abort_out_valid", out_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_pulse", {crc_ok, crc_err}, 0);
    for (int i = 0; i < FB-1; i++) pay[i] = 8'(8'h10 * i + 3);
    send_frame(frame_crc());

    for (int i = 0; i < FB-1; i++) pay[i] = 8'h00;
    pay[FB-2] = 8'h01;
    send_frame(8'h06);

    tog_en = 1'b1;
    for (int i = 0; i < FB-1; i++) pay[i] = 8'($urandom_range(0, 255));
    send_frame(frame_crc());
    for (int i = 0; i < FB-1; i++) pay[i] = 8'($urandom_range(0, 255));
    send_frame(frame_crc() ^ 8'h5A);
    tog_en = 1'b0;

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FB-1; i++) pay[i] = 8'($urandom_range(0, 255));
      if (f[0]) send_frame(frame_crc() ^ 8'h01);
      else send_frame(frame_crc());
    end

    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    exp_errs = 16'hFFFE;
    @(negedge clk);
    check("preload", err_count, 16'hFFFE);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FB-1; i++) pay[i] = 8'($urandom_range(0, 255));
      send_frame(frame_crc() ^ 8'h80);
    end
    check("sat_hold", err_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/crc_frame_check.md
Name: crc_frame_check

Overview:
Receive-side stage that sits directly downstream of the CRC-8 generator. It consumes the generator's byte stream, framed as FRAME_BYTES-1 payload bytes followed by one CRC byte. It recomputes CRC-8 over the payload, compares the result with the received CRC byte, and buffers the payload. After the check it releases the payload on a valid/ready output tagged with the check result, and it keeps a running error count.

Parameters:
FRAME_BYTES, 8, total bytes per frame including the trailing CRC byte (min 2, max 16)
POLY, 8'h07, CRC-8 generator polynomial (MSB-first, no reflection, no final XOR)
INIT, 8'h00, CRC register value at start of every frame

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (asserted at 0)
in_data  input  8  incoming byte (payload or CRC)
in_valid  input  1  in_data valid this cycle
in_ready  output  1  block accepts a byte this cycle
out_data  output  8  released payload byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  marks last payload byte of a frame; qualified by out_valid
out_err  output  1  frame failed CRC; constant across a frame's output bytes
crc_ok  output  1  one-cycle pulse: frame passed
crc_err  output  1  one-cycle pulse: frame failed
err_count  output  16  saturating count of failed frames

Behaviour:
- Reset (reset=0, async) sets state to RECV and byte index to 0, loads crc with INIT, and clears the buffer pointers.
- Output reset values: in_ready=1, out_valid=0, out_last=0, out_err=0, crc_ok=0, crc_err=0, err_count=0, out_data=0.
- Reset mid-frame or mid-drain discards all partial data; no pulse is generated.
- Accept condition: in_valid & in_ready. Payload and CRC bytes are accepted only in RECV.
- RECV state:
  - in_ready=1.
  - Each payload byte (index 0..FRAME_BYTES-2): byte is written to buffer[index]; crc is updated to crc8(crc ^ in_data), using 8 MSB-first shift/XOR steps with POLY in a single cycle; index increments.
  - At index FRAME_BYTES-1 the accepted byte is the CRC byte. The received byte is compared with the current crc register; the match bit is registered; go to CHECK.
- CHECK state (exactly 1 cycle):
  - in_ready=0.
  - crc_ok or crc_err pulses high for this cycle only, so the pulse comes 1 cycle after the CRC byte is accepted.
  - On mismatch, err_count increments, saturating at 16'hFFFF.
  - out_err is latched for the drain that follows.
  - Go to DRAIN, with read pointer 0.
- DRAIN state:
  - in_ready=0.
  - out_valid=1 and out_data=buffer[rptr].
  - On out_valid & out_ready, rptr increments. out_last=1 when rptr==FRAME_BYTES-2.
  - Handshaking the last byte returns the state to RECV, reloads crc with INIT and sets index to 0.
  - First out_valid comes 2 cycles after the CRC byte is accepted.
- Backpressure: while out_ready=0, out_valid stays high and out_data, out_last and out_err are held stable.
- Input bytes presented during CHECK/DRAIN are not accepted (in_ready=0); upstream must hold or retry.
- CRC arithmetic is 8-bit modulo-2. Index and rptr are clog2(FRAME_BYTES) bits wide; there is no wrap beyond the frame length.
- Frame throughput: FRAME_BYTES accept cycles + 1 check cycle + (FRAME_BYTES-1) drain cycles, minimum.

Optional Feature:
CRC_DROP_BAD_EN:
- Defined: on a CRC mismatch, CHECK goes directly to RECV. The payload is discarded, out_valid never asserts for that frame, and out_err stays 0. crc_err and err_count behave as normal.
- Undefined: every frame drains, and failed frames are tagged with out_err=1.

Test Plan:
- Payload 00 00 00 00 00 00 00 + CRC 00, out_ready=1 -> crc_ok pulse 1 cycle after CRC byte; 7 bytes of 00 out starting 2 cycles after; out_last on 7th; out_err=0; err_count=0.
- Payload 00 00 00 00 00 00 01 + CRC 07 -> crc_ok; out_data sequence ends 01 with out_last=1.
- Same payload + CRC 06 -> crc_err pulse; err_count=1. Macro undefined: 7 bytes out with out_err=1. Macro defined: no out_valid, in_ready=1 on the cycle after CHECK.
- Good frame with out_ready toggling 1,0,0,1 repeatedly -> out_data held stable while stalled; exactly 7 handshakes; in_ready=0 until last handshake, then 1.
- Assert reset=0 after 4 payload bytes, release, send a full good frame -> no pulse from the aborted frame; new frame crc_ok; err_count=0.
- Preload err_count to 16'hFFFE by sending 65534 bad frames (or force), then send 2 more bad frames -> err_count=16'hFFFF and holds; crc_err still pulses each time.
